cheat_pgm_writer: RTL

//  MCU-side programming front end for the cheat/hook engine. Takes byte bursts from the MCU

---
 rtl/cheat_pkg.sv | 17 +
 rtl/cheat_pgm_shadow.sv | 38 +++
 rtl/cheat_pgm_writer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cheat_pkg.sv
// Shared constants and types for the cheat/hook engine, its MCU command
// decoder and the program writer.
package cheat_pkg;

    // Slots 0..5 hold patch address/data, then the enable mask, then global flags.
    localparam int unsigned NUM_PATCH_SLOTS    = 6;
    localparam int unsigned SLOT_MASK          = NUM_PATCH_SLOTS;
    localparam int unsigned SLOT_GLOBAL        = SLOT_MASK + 1;
    localparam int unsigned CHEAT_NUM_SLOTS    = SLOT_GLOBAL + 1;
    localparam int unsigned CHEAT_TIMEOUT_CLKS = 96;

    typedef enum logic [0:0] {
        IDLE,
        ACTIVE
    } cheat_pgm_state_e;

endpackage

// File: rtl/cheat_pgm_shadow.sv
// Readback copy of the cheat program slots. Only present in builds that
// define CHEAT_PGM_READBACK_EN.
`ifdef CHEAT_PGM_READBACK_EN
module cheat_pgm_shadow #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [NUM_SLOTS];
    logic [31:0] rdata_q;

    // Capture committed words and register the read port (1-clk latency).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we) begin
                mem_q[waddr] <= wdata;
            end
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule
`endif

// File: rtl/cheat_pgm_writer.sv
// MCU-side program writer for the cheat engine: packs burst bytes big-endian
// into words and commits them to the slot program on SNES bus-cycle
// boundaries (or after a timeout when the SNES is not running).
// Optional readback shadow enabled by defining CHEAT_PGM_READBACK_EN.
module cheat_pgm_writer
    import cheat_pkg::*;
#(
    parameter int unsigned NUM_SLOTS    = CHEAT_NUM_SLOTS,
    parameter int unsigned IDX_W        = 3,
    parameter int unsigned TIMEOUT_CLKS = CHEAT_TIMEOUT_CLKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             burst_start,
    input  logic [IDX_W-1:0] burst_idx,
    input  logic [3:0]       burst_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    input  logic             SNES_cycle_start,
    output logic [IDX_W-1:0] pgm_idx,
    output logic             pgm_we,
    output logic [31:0]      pgm_in,
    output logic             busy,
    output logic             overrun,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SLOTS - 1);

    cheat_pgm_state_e state_q, state_d;
    logic [23:0]      asm_word_q, asm_word_d;   // first three bytes; 4th comes straight from byte_in
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       words_left_q, words_left_d;
    logic [31:0]      cmt_word_q, cmt_word_d;
    logic [IDX_W-1:0] cmt_idx_q, cmt_idx_d;
    logic             cmt_pend_q, cmt_pend_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             pgm_we_q, pgm_we_d;
    logic [IDX_W-1:0] pgm_idx_q, pgm_idx_d;
    logic [31:0]      pgm_in_q, pgm_in_d;
    logic             overrun_q, overrun_d;

    logic             word_done;
    logic [31:0]      word_full;
    logic             commit;
    logic             load;

    // Burst FSM and byte assembly.
    always_comb begin
        state_d      = state_q;
        asm_word_d   = asm_word_q;
        byte_cnt_d   = byte_cnt_q;
        idx_d        = idx_q;
        words_left_d = words_left_q;
        word_done    = 1'b0;
        word_full    = {asm_word_q, byte_in};

        if (burst_start) begin
            // A new burst discards any partial word; a byte on the same clk is byte 0.
            state_d      = ACTIVE;
            idx_d        = burst_idx;
            words_left_d = (burst_words == 4'd0) ? 4'd1 : burst_words;
            asm_word_d   = '0;
            byte_cnt_d   = 2'd0;
            if (byte_valid) begin
                asm_word_d = {byte_in, 16'h0000};
                byte_cnt_d = 2'd1;
            end
        end else if (state_q == ACTIVE && byte_valid) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            unique case (byte_cnt_q)
                2'd0: asm_word_d[23:16] = byte_in;
                2'd1: asm_word_d[15:8]  = byte_in;
                2'd2: asm_word_d[7:0]   = byte_in;
                2'd3: begin
                    word_done    = 1'b1;
                    idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    words_left_d = words_left_q - 4'd1;
                    if (words_left_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Commit register, aligned write strobe and overrun tracking.
    always_comb begin
        commit     = cmt_pend_q & (SNES_cycle_start | (tmo_q == TMO_LAST));
        // A word finishing on the clk the pending one commits is still accepted.
        load       = word_done & (~cmt_pend_q | commit);
        cmt_word_d = cmt_word_q;
        cmt_idx_d  = cmt_idx_q;
        cmt_pend_d = cmt_pend_q;
        tmo_d      = tmo_q;
        pgm_we_d   = commit;
        pgm_idx_d  = pgm_idx_q;
        pgm_in_d   = pgm_in_q;
        overrun_d  = overrun_q;

        if (cmt_pend_q && tmo_q != TMO_LAST) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (commit) begin
            cmt_pend_d = 1'b0;
            pgm_idx_d  = cmt_idx_q;
            pgm_in_d   = cmt_word_q;
        end
        if (load) begin
            cmt_word_d = word_full;
            cmt_idx_d  = idx_q;
            cmt_pend_d = 1'b1;
            tmo_d      = '0;
        end
        if (burst_start) begin
            overrun_d = 1'b0;
        end else if (word_done && !load) begin
            overrun_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            asm_word_q   <= '0;
            byte_cnt_q   <= '0;
            idx_q        <= '0;
            words_left_q <= '0;
            cmt_word_q   <= '0;
            cmt_idx_q    <= '0;
            cmt_pend_q   <= 1'b0;
            tmo_q        <= '0;
            pgm_we_q     <= 1'b0;
            pgm_idx_q    <= '0;
            pgm_in_q     <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            asm_word_q   <= asm_word_d;
            byte_cnt_q   <= byte_cnt_d;
            idx_q        <= idx_d;
            words_left_q <= words_left_d;
            cmt_word_q   <= cmt_word_d;
            cmt_idx_q    <= cmt_idx_d;
            cmt_pend_q   <= cmt_pend_d;
            tmo_q        <= tmo_d;
            pgm_we_q     <= pgm_we_d;
            pgm_idx_q    <= pgm_idx_d;
            pgm_in_q     <= pgm_in_d;
            overrun_q    <= overrun_d;
        end
    end

    assign pgm_we  = pgm_we_q;
    assign pgm_idx = pgm_idx_q;
    assign pgm_in  = pgm_in_q;
    assign overrun = overrun_q;
    assign busy    = (state_q == ACTIVE) | cmt_pend_q | pgm_we_q;

`ifdef CHEAT_PGM_READBACK_EN
    cheat_pgm_shadow #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (pgm_we_q),
        .waddr (pgm_idx_q),
        .wdata (pgm_in_q),
        .raddr (rd_idx),
        .rdata (rd_data)
    );
`else
    logic [IDX_W-1:0] unused_rd_idx;
    assign unused_rd_idx = rd_idx;
    assign rd_data       = '0;
`endif

endmodule
